pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised fetch-address sequencer for the MIPS32 datapath. It replaces the single-cycle next-PC register.
- Holds the architectural PC and computes the sequential, branch, jump, jump-register, exception and return-from-exception targets.
- Supports pipeline stall with a one-deep pending-redirect buffer, and captures EPC on exceptions.
- Sits between the control unit/ALU and the instruction memory address port.

Parameters:
- ADDR_W, 32: PC width in bits. Legal range 29..64.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0180: exception handler entry address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the PC; redirects arriving while high are buffered.
- branch  in  1  conditional branch decoded.
- alu_zero  in  1  ALU zero flag; a branch is taken when branch && alu_zero.
- branch_offset  in  ADDR_W  sign-extended 16-bit immediate (word offset).
- jump  in  1  J/JAL decoded.
- jump_index  in  26  instr_index field.
- jump_reg  in  1  JR/JALR decoded.
- jump_reg_target  in  ADDR_W  rs register value.
- exception  in  1  exception request.
- eret  in  1  return from exception.
- pc  out  ADDR_W  current fetch address.
- pc_plus4  out  ADDR_W  pc + 4 (link value).
- epc  out  ADDR_W  saved exception PC.
- redirect_pending  out  1  a buffered redirect is waiting.
- align_err  out  1  one-cycle pulse when the JR target is misaligned.

Behaviour:
- Reset, synchronous, highest priority:
  - pc = RESET_VECTOR, epc = 0, redirect_pending = 0, align_err = 0.
  - Pending buffer cleared.
  - Reset during a stall or with a pending redirect discards everything.
- Target arithmetic, all modulo 2^ADDR_W:
  - seq = pc + 4. Wrap from all-ones-minus-3 to 0 is silent.
  - br = pc + 4 + (branch_offset << 2).
  - jmp = {pc_plus4[ADDR_W-1:28], jump_index, 2'b00}.
  - jr = {jump_reg_target[ADDR_W-1:2], 2'b00}. align_err = 1 on the next cycle if jump_reg_target[1:0] != 0.
- Source priority per cycle: exception > eret > jump_reg > branch-taken > jump > sequential.
- Normal cycle (stall = 0, no pending redirect):
  - pc <= highest-priority target.
  - Latency is 1 cycle: a redirect asserted in cycle N gives the new pc in cycle N+1.
- Exception:
  - Acts even when stall = 1.
  - epc <= pc. pc <= EXC_VECTOR.
  - Pending buffer cleared.
- eret: pc <= epc.
- Stall (stall = 1, no exception):
  - pc holds.
  - Any non-sequential redirect is written into the pending buffer and redirect_pending <= 1.
  - A later redirect in the same stall overwrites the buffer, unless the buffer holds an eret and the new source has lower priority.
- Release (first cycle with stall = 0 and redirect_pending = 1):
  - pc <= buffered target and redirect_pending <= 0. Live inputs that cycle are ignored, except exception, which wins.
- FSM states:
  - RUN → STALL_EMPTY when stall.
  - STALL_EMPTY → STALL_PEND on a redirect.
  - STALL_PEND → DRAIN when stall drops.
  - DRAIN → RUN after one cycle.
  - STALL_EMPTY → RUN when stall drops.
  - Any state → RUN on exception or reset.
- Simultaneous branch-taken and jump: the branch wins. jump_reg together with exception: the exception wins and epc = pc.
- pc[1:0] is always 00.

Decomposition:
- pc_pkg holds:
  - The redirect-source enum (SRC_SEQ, SRC_JMP, SRC_BR, SRC_JR, SRC_ERET, SRC_EXC).
  - The FSM state enum.
  - The constant INSTR_BYTES = 4.
- Sub-module pc_target_calc: purely combinational; computes seq/br/jmp/jr and align_err_next.
- The top level owns the registers, the FSM and the pending buffer.

Test Plan:
- Reset with pc = 0x40 → pc = 0x0, epc = 0, redirect_pending = 0 next cycle. Then 3 idle cycles → pc = 0x4, 0x8, 0xC.
- pc = 0x100, branch = 1, alu_zero = 1, offset = 0xFFFF_FFFE → pc = 0xFC. Same stimulus with alu_zero = 0 → pc = 0x104.
- pc = 0x1000_0010, jump = 1, index = 0x000_0040 → pc = 0x1000_0100. Adding branch-taken in the same cycle → branch target wins.
- stall = 1 for 3 cycles with jump_reg target 0x203 in cycle 2:
  - pc held, redirect_pending = 1, align_err pulse.
  - After release: pc = 0x200 at DRAIN+1, then 0x204.
- pc = 0x300, exception while stall = 1 with a pending JR → pc = 0x180, epc = 0x300, pending cleared. Then eret → pc = 0x300.
- ADDR_W = 32, pc = 0xFFFF_FFFC, idle → pc = 0x0 with no error.

Source files
------------

// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg : shared types and constants for the fetch-address sequencer
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pc_pkg;

  localparam int INSTR_BYTES = 4;

  // Encoded in ascending priority so sources can be compared by magnitude.
  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_JMP  = 3'd1,
    SRC_BR   = 3'd2,
    SRC_JR   = 3'd3,
    SRC_ERET = 3'd4,
    SRC_EXC  = 3'd5
  } src_e;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_STALL_EMPTY = 2'd1,
    ST_STALL_PEND  = 2'd2,
    ST_DRAIN       = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pc_target_calc.sv
// ---------------------------------------------------------------------------
// pc_target_calc : combinational next-PC candidate targets
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_target_calc
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic [25:0]       jump_index,
  input  logic [ADDR_W-1:0] jump_reg_target,
  output logic [ADDR_W-1:0] seq,
  output logic [ADDR_W-1:0] br,
  output logic [ADDR_W-1:0] jmp,
  output logic [ADDR_W-1:0] jr,
  output logic              align_err_next
);

  assign seq = pc + ADDR_W'(INSTR_BYTES);
  assign br  = seq + (branch_offset << 2);
  // Jump region comes from the delay-slot address, not the jump itself.
  assign jmp = {seq[ADDR_W-1:28], jump_index, 2'b00};
  assign jr  = {jump_reg_target[ADDR_W-1:2], 2'b00};

  assign align_err_next = |jump_reg_target[1:0];

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer : architectural PC, EPC, stall FSM and pending-redirect buffer
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h0000_0180)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch,
  input  logic              alu_zero,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              jump_reg,
  input  logic [ADDR_W-1:0] jump_reg_target,
  input  logic              exception,
  input  logic              eret,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] epc,
  output logic              redirect_pending,
  output logic              align_err
);

  logic [ADDR_W-1:0] seq, br, jmp, jr;
  logic              align_err_next;

  state_e            state, state_next;
  src_e              live_src, pend_src;
  logic [ADDR_W-1:0] live_target, pend_target, pc_next;
  logic              buf_we, buf_clr, epc_we, keep_eret;

  pc_target_calc #(.ADDR_W(ADDR_W)) u_calc (
    .pc              (pc),
    .branch_offset   (branch_offset),
    .jump_index      (jump_index),
    .jump_reg_target (jump_reg_target),
    .seq             (seq),
    .br              (br),
    .jmp             (jmp),
    .jr              (jr),
    .align_err_next  (align_err_next)
  );

  assign pc_plus4         = seq;
  assign redirect_pending = (state == ST_STALL_PEND);

  always_comb begin
    live_src    = SRC_SEQ;
    live_target = seq;
    if (exception) begin
      live_src    = SRC_EXC;
      live_target = EXC_VECTOR;
    end else if (eret) begin
      live_src    = SRC_ERET;
      live_target = epc;
    end else if (jump_reg) begin
      live_src    = SRC_JR;
      live_target = jr;
    end else if (branch && alu_zero) begin
      live_src    = SRC_BR;
      live_target = br;
    end else if (jump) begin
      live_src    = SRC_JMP;
      live_target = jmp;
    end
  end

  // A buffered eret may only be displaced by another eret.
  assign keep_eret = (state == ST_STALL_PEND) && (pend_src == SRC_ERET)
                     && (live_src < SRC_ERET);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    buf_we     = 1'b0;
    buf_clr    = 1'b0;
    epc_we     = 1'b0;
    if (exception) begin
      pc_next    = EXC_VECTOR;
      epc_we     = 1'b1;
      buf_clr    = 1'b1;
      state_next = ST_RUN;
    end else if (stall) begin
      if (live_src != SRC_SEQ && !keep_eret) begin
        buf_we     = 1'b1;
        state_next = ST_STALL_PEND;
      end else if (state != ST_STALL_PEND) begin
        state_next = ST_STALL_EMPTY;
      end
    end else if (state == ST_STALL_PEND) begin
      pc_next    = pend_target;
      buf_clr    = 1'b1;
      state_next = ST_DRAIN;
    end else begin
      pc_next    = live_target;
      state_next = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_VECTOR;
      epc         <= '0;
      pend_src    <= SRC_SEQ;
      pend_target <= '0;
      align_err   <= 1'b0;
    end else begin
      pc        <= pc_next;
      align_err <= jump_reg && !exception && align_err_next;
      if (epc_we) epc <= pc;
      if (buf_clr) begin
        pend_src    <= SRC_SEQ;
        pend_target <= '0;
      end else if (buf_we) begin
        pend_src    <= live_src;
        pend_target <= live_target;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer : scoreboard bench for pc_sequencer (ADDR_W = 32)
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, branch, alu_zero, jump, jump_reg, exception, eret;
  logic [31:0] branch_offset, jump_reg_target;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus4, epc;
  logic        redirect_pending, align_err;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic rst, stl, br, az;
    logic [31:0] boff;
    logic jmp;
    logic [25:0] jidx;
    logic jr;
    logic [31:0] jrt;
    logic exc, eret;
    logic [31:0] pc, epc;
    logic pend, aerr;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc, epc;
    logic pend, aerr;
  } exp_t;

  exp_t exp_q[$];

  pc_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .branch           (branch),
    .alu_zero         (alu_zero),
    .branch_offset    (branch_offset),
    .jump             (jump),
    .jump_index       (jump_index),
    .jump_reg         (jump_reg),
    .jump_reg_target  (jump_reg_target),
    .exception        (exception),
    .eret             (eret),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .epc              (epc),
    .redirect_pending (redirect_pending),
    .align_err        (align_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    reset = s.rst; stall = s.stl; branch = s.br; alu_zero = s.az;
    branch_offset = s.boff; jump = s.jmp; jump_index = s.jidx;
    jump_reg = s.jr; jump_reg_target = s.jrt; exception = s.exc; eret = s.eret;
    e.pc = s.pc; e.epc = s.epc; e.pend = s.pend; e.aerr = s.aerr;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    stim_t v[7];
    exp_t  e;
    v[0] = '{1,1,0,0,0,0,0,0,0,0,0, 32'h0,  0,0,0};
    v[1] = '{0,0,0,0,0,0,0,1,32'h40,0,0, 32'h40, 0,0,0};
    v[2] = '{0,1,0,0,0,0,0,1,32'h80,0,0, 32'h40, 0,1,0};
    v[3] = '{1,1,0,0,0,0,0,0,0,0,0, 32'h0,  0,0,0};
    v[4] = '{0,0,0,0,0,0,0,0,0,0,0, 32'h4,  0,0,0};
    v[5] = '{0,0,0,0,0,0,0,0,0,0,0, 32'h8,  0,0,0};
    v[6] = '{0,0,0,0,0,0,0,0,0,0,0, 32'hC,  0,0,0};
    foreach (v[i]) begin
      drive(v[i]); tick(); e = exp_q.pop_front(); checks++;
      if ({pc, pc_plus4, epc, redirect_pending, align_err} !== {e.pc, e.pc + 32'd4, e.epc, e.pend, e.aerr}) begin
        failures++;
        $display("FAIL reset[%0d] got pc=%h pc4=%h epc=%h pend=%b aerr=%b exp pc=%h epc=%h pend=%b aerr=%b",
                 i, pc, pc_plus4, epc, redirect_pending, align_err, e.pc, e.epc, e.pend, e.aerr);
      end
    end
  endtask

  task automatic test_branch();
    stim_t v[4];
    exp_t  e;
    v[0] = '{0,0,0,0,0,0,0,1,32'h100,0,0, 32'h100, 0,0,0};
    v[1] = '{0,0,1,1,32'hFFFF_FFFE,0,0,0,0,0,0, 32'hFC, 0,0,0};
    v[2] = '{0,0,0,0,0,0,0,1,32'h100,0,0, 32'h100, 0,0,0};
    v[3] = '{0,0,1,0,32'hFFFF_FFFE,0,0,0,0,0,0, 32'h104, 0,0,0};
    foreach (v[i]) begin
      drive(v[i]); tick(); e = exp_q.pop_front(); checks++;
      if ({pc, pc_plus4, epc, redirect_pending, align_err} !== {e.pc, e.pc + 32'd4, e.epc, e.pend, e.aerr}) begin
        failures++;
        $display("FAIL branch[%0d] got pc=%h pc4=%h epc=%h pend=%b aerr=%b exp pc=%h epc=%h pend=%b aerr=%b",
                 i, pc, pc_plus4, epc, redirect_pending, align_err, e.pc, e.epc, e.pend, e.aerr);
      end
    end
  endtask

  task automatic test_jump();
    stim_t v[4];
    exp_t  e;
    v[0] = '{0,0,0,0,0,0,0,1,32'h1000_0010,0,0, 32'h1000_0010, 0,0,0};
    v[1] = '{0,0,0,0,0,1,26'h40,0,0,0,0, 32'h1000_0100, 0,0,0};
    v[2] = '{0,0,0,0,0,0,0,1,32'h1000_0010,0,0, 32'h1000_0010, 0,0,0};
    v[3] = '{0,0,1,1,32'h10,1,26'h40,0,0,0,0, 32'h1000_0054, 0,0,0};
    foreach (v[i]) begin
      drive(v[i]); tick(); e = exp_q.pop_front(); checks++;
      if ({pc, pc_plus4, epc, redirect_pending, align_err} !== {e.pc, e.pc + 32'd4, e.epc, e.pend, e.aerr}) begin
        failures++;
        $display("FAIL jump[%0d] got pc=%h pc4=%h epc=%h pend=%b aerr=%b exp pc=%h epc=%h pend=%b aerr=%b",
                 i, pc, pc_plus4, epc, redirect_pending, align_err, e.pc, e.epc, e.pend, e.aerr);
      end
    end
  endtask

  task automatic test_stall();
    stim_t v[10];
    exp_t  e;
    v[0] = '{0,0,0,0,0,0,0,1,32'h400,0,0, 32'h400, 0,0,0};
    v[1] = '{0,1,0,0,0,0,0,0,0,0,0, 32'h400, 0,0,0};
    v[2] = '{0,1,0,0,0,0,0,1,32'h203,0,0, 32'h400, 0,1,1};
    v[3] = '{0,1,0,0,0,0,0,0,0,0,0, 32'h400, 0,1,0};
    v[4] = '{0,0,0,0,0,1,26'h40,0,0,0,0, 32'h200, 0,0,0};
    v[5] = '{0,0,0,0,0,0,0,0,0,0,0, 32'h204, 0,0,0};
    v[6] = '{0,1,0,0,0,0,0,0,0,0,1, 32'h204, 0,1,0};
    v[7] = '{0,1,0,0,0,0,0,1,32'h600,0,0, 32'h204, 0,1,0};
    v[8] = '{0,0,0,0,0,0,0,0,0,0,0, 32'h0, 0,0,0};
    v[9] = '{0,0,0,0,0,0,0,0,0,0,0, 32'h4, 0,0,0};
    foreach (v[i]) begin
      drive(v[i]); tick(); e = exp_q.pop_front(); checks++;
      if ({pc, pc_plus4, epc, redirect_pending, align_err} !== {e.pc, e.pc + 32'd4, e.epc, e.pend, e.aerr}) begin
        failures++;
        $display("FAIL stall[%0d] got pc=%h pc4=%h epc=%h pend=%b aerr=%b exp pc=%h epc=%h pend=%b aerr=%b",
                 i, pc, pc_plus4, epc, redirect_pending, align_err, e.pc, e.epc, e.pend, e.aerr);
      end
    end
  endtask

  task automatic test_exception();
    stim_t v[7];
    exp_t  e;
    v[0] = '{0,0,0,0,0,0,0,1,32'h300,0,0, 32'h300, 32'h0,0,0};
    v[1] = '{0,1,0,0,0,0,0,1,32'h208,0,0, 32'h300, 32'h0,1,0};
    v[2] = '{0,1,0,0,0,0,0,0,0,1,0, 32'h180, 32'h300,0,0};
    v[3] = '{0,0,0,0,0,0,0,0,0,0,0, 32'h184, 32'h300,0,0};
    v[4] = '{0,0,0,0,0,0,0,0,0,0,1, 32'h300, 32'h300,0,0};
    v[5] = '{0,0,0,0,0,0,0,1,32'h500,1,0, 32'h180, 32'h300,0,0};
    v[6] = '{0,0,0,0,0,0,0,0,0,0,1, 32'h300, 32'h300,0,0};
    foreach (v[i]) begin
      drive(v[i]); tick(); e = exp_q.pop_front(); checks++;
      if ({pc, pc_plus4, epc, redirect_pending, align_err} !== {e.pc, e.pc + 32'd4, e.epc, e.pend, e.aerr}) begin
        failures++;
        $display("FAIL exception[%0d] got pc=%h pc4=%h epc=%h pend=%b aerr=%b exp pc=%h epc=%h pend=%b aerr=%b",
                 i, pc, pc_plus4, epc, redirect_pending, align_err, e.pc, e.epc, e.pend, e.aerr);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t v[4];
    exp_t  e;
    v[0] = '{0,0,0,0,0,0,0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC, 32'h300,0,0};
    v[1] = '{0,0,0,0,0,0,0,0,0,0,0, 32'h0, 32'h300,0,0};
    v[2] = '{0,0,0,0,0,0,0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC, 32'h300,0,0};
    v[3] = '{0,0,1,1,32'h1,0,0,0,0,0,0, 32'h4, 32'h300,0,0};
    foreach (v[i]) begin
      drive(v[i]); tick(); e = exp_q.pop_front(); checks++;
      if ({pc, pc_plus4, epc, redirect_pending, align_err} !== {e.pc, e.pc + 32'd4, e.epc, e.pend, e.aerr}) begin
        failures++;
        $display("FAIL wrap[%0d] got pc=%h pc4=%h epc=%h pend=%b aerr=%b exp pc=%h epc=%h pend=%b aerr=%b",
                 i, pc, pc_plus4, epc, redirect_pending, align_err, e.pc, e.epc, e.pend, e.aerr);
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch = 1'b0; alu_zero = 1'b0; jump = 1'b0;
    jump_reg = 1'b0; exception = 1'b0; eret = 1'b0;
    branch_offset = '0; jump_reg_target = '0; jump_index = '0;
    test_reset();
    test_branch();
    test_jump();
    test_stall();
    test_exception();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
